// File: rtl/fifo_unpacker.sv
// fifo_unpacker: pops wide FIFO words and streams them out as narrow chunks, LS chunk first
module fifo_unpacker #(
   parameter int WORD_W  = 64,
   parameter int CHUNK_W = 16,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WORD_W-1:0]  fifo_data_out,
   input  logic               fifo_empty,
   output logic               pop_fifo,
   output logic [CHUNK_W-1:0] chunk_out,
   output logic               chunk_valid,
   input  logic               chunk_ready,
   output logic               chunk_last,
   output logic [CNT_W-1:0]   word_count
);
   localparam int NCHUNK = WORD_W / CHUNK_W;
   localparam int IDX_W  = $clog2(NCHUNK);
   typedef enum logic {EMPTY, HOLD} state_t;
   state_t             state, state_nx;
   logic [WORD_W-1:0]  word_reg, word_nx;
   logic [IDX_W-1:0]   idx, idx_nx;
   logic [CNT_W-1:0]   count_nx;
   logic [CHUNK_W-1:0] chunks [NCHUNK];
   logic               accept, take;
   for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
      assign chunks[i] = word_reg[i*CHUNK_W +: CHUNK_W];
   end
   assign chunk_valid = (state == HOLD);
   assign chunk_last  = chunk_valid & (idx == IDX_W'(NCHUNK-1));
   assign chunk_out   = chunks[idx];
   assign accept      = chunk_valid & chunk_ready;
   assign take        = ~chunk_valid | (accept & chunk_last);
   assign pop_fifo    = rst_n & ~fifo_empty & take;
   // next state: a pop loads a fresh word (even on the last-chunk accept), otherwise step or go idle
   always_comb begin
      state_nx = state;
      word_nx  = word_reg;
      idx_nx   = idx;
      count_nx = word_count;
      if (pop_fifo) begin
         state_nx = HOLD;
         word_nx  = fifo_data_out;
         idx_nx   = '0;
         count_nx = word_count + CNT_W'(1);
      end else if (accept & ~chunk_last) begin
         idx_nx   = idx + IDX_W'(1);
      end else if (accept) begin
         state_nx = EMPTY;
         idx_nx   = '0;
      end
   end
   // state registers; asynchronous reset discards any partially sent word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         word_reg   <= '0;
         idx        <= '0;
         word_count <= '0;
      end else begin
         state      <= state_nx;
         word_reg   <= word_nx;
         idx        <= idx_nx;
         word_count <= count_nx;
      end
   end
endmodule

// File: tb/tb_fifo_unpacker.sv
// tb_fifo_unpacker: randomized scoreboard bench with a queue-based FIFO and chunk model
module tb_fifo_unpacker;
   logic        clk = 0;
   logic        rst_n = 1;
   logic [63:0] fifo_data_out = '0;
   logic        fifo_empty = 1;
   logic        pop_fifo;
   logic [15:0] chunk_out;
   logic        chunk_valid;
   logic        chunk_ready = 0;
   logic        chunk_last;
   logic [7:0]  word_count;

   logic [63:0] fq[$];
   logic [15:0] exp_q[$];
   logic        exp_last_q[$];
   int          checks = 0, errors = 0, sent = 0, pops = 0;

   fifo_unpacker #(.WORD_W(64), .CHUNK_W(16), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
      .pop_fifo(pop_fifo), .chunk_out(chunk_out), .chunk_valid(chunk_valid),
      .chunk_ready(chunk_ready), .chunk_last(chunk_last), .word_count(word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic upd();
      fifo_empty    = (fq.size() == 0);
      fifo_data_out = (fq.size() != 0) ? fq[0] : 64'h0;
   endtask

   task automatic push(input logic [63:0] w);
      fq.push_back(w);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(w[k*16 +: 16]);
         exp_last_q.push_back(k == 3);
      end
      sent++;
      upd();
   endtask

   task automatic wait_drain(input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk); #3;
         if (exp_q.size() == 0 && !chunk_valid && fq.size() == 0) done = 1;
      end
      if (!done) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   // FIFO model: head leaves on the edge where the DUT pops
   initial begin
      logic pq;
      forever begin
         @(negedge clk); #1;
         pq = pop_fifo;
         @(posedge clk); #1;
         if (pq && fq.size() != 0) void'(fq.pop_front());
         upd();
      end
   end

   // monitor: compares every accepted chunk with the scoreboard and checks pop/stall rules
   initial begin
      logic        stalled = 0, prev_last = 0;
      logic [15:0] prev_out = '0;
      forever begin
         @(negedge clk); #2;
         if (!rst_n) stalled = 0;
         else begin
            if (fifo_empty) chk("pop_on_empty", pop_fifo, 0);
            if (chunk_last && !chunk_ready) chk("pop_on_stalled_last", pop_fifo, 0);
            if (stalled) begin
               chk("stall_valid", chunk_valid, 1);
               chk("stall_data", chunk_out, prev_out);
               chk("stall_last", chunk_last, prev_last);
            end
            if (pop_fifo) pops++;
            if (chunk_valid && chunk_ready) begin
               if (exp_q.size() == 0) chk("unexpected_chunk", chunk_out, 64'hdead);
               else begin
                  chk("chunk_data", chunk_out, exp_q.pop_front());
                  chk("chunk_last", chunk_last, exp_last_q.pop_front());
               end
            end
            stalled   = chunk_valid && !chunk_ready;
            prev_out  = chunk_out;
            prev_last = chunk_last;
         end
      end
   end

   initial begin
      int p0, run, n;
      logic [63:0] w;
      #1 rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      // idle with an empty FIFO
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #3;
         chk("idle_pop", pop_fifo, 0);
         chk("idle_valid", chunk_valid, 0);
         chk("idle_count", word_count, 0);
      end
      // single known word
      @(negedge clk);
      chunk_ready = 1;
      p0 = pops;
      push(64'h4444_3333_2222_1111);
      wait_drain(20);
      chk("single_pops", pops - p0, 1);
      chk("single_count", word_count, sent % 256);
      // three queued words stream back to back
      @(negedge clk);
      p0 = pops;
      for (int i = 0; i < 3; i++) push({$urandom, $urandom});
      run = 0;
      for (int i = 0; i < 10 && !chunk_valid; i++) begin @(negedge clk); #3; end
      while (chunk_valid && run < 20) begin run++; @(negedge clk); #3; end
      chk("burst_valid_run", run, 12);
      wait_drain(20);
      chk("burst_pops", pops - p0, 3);
      chk("burst_count", word_count, sent % 256);
      // stalling sink, ready pattern 1,0,0
      @(negedge clk);
      for (int i = 0; i < 3; i++) push({$urandom, $urandom});
      for (int i = 0; i < 45; i++) begin
         chunk_ready = (i % 3 == 0);
         @(negedge clk);
      end
      chunk_ready = 1;
      wait_drain(40);
      chk("stall_count", word_count, sent % 256);
      // asynchronous reset in the middle of a word (idx 2)
      @(negedge clk);
      w = 64'hdddd_cccc_bbbb_aaaa;
      push(w);
      repeat (3) @(negedge clk);
      chunk_ready = 0;
      push({$urandom, $urandom});
      #3;
      chk("pre_reset_chunk2", chunk_out, 16'hcccc);
      rst_n = 0;
      #1;
      chk("rst_valid", chunk_valid, 0);
      chk("rst_data", chunk_out, 0);
      chk("rst_last", chunk_last, 0);
      chk("rst_count", word_count, 0);
      chk("rst_pop", pop_fifo, 0);
      repeat (2) begin @(negedge clk); #3; chk("rst_pop_hold", pop_fifo, 0); end
      fq.delete(); exp_q.delete(); exp_last_q.delete(); sent = 0; upd();
      #1 rst_n = 1;
      @(negedge clk);
      chunk_ready = 1;
      push(64'h8888_7777_6666_5555);
      wait_drain(20);
      chk("post_reset_count", word_count, sent % 256);
      // 256 random words with random back-pressure; word_count wraps
      n = 0;
      for (int i = 0; i < 6000 && n < 256; i++) begin
         @(negedge clk);
         chunk_ready = ($urandom % 4) != 0;
         if (fq.size() < 4 && ($urandom % 2) == 1) begin push({$urandom, $urandom}); n++; end
      end
      chk("random_pushed", n, 256);
      chunk_ready = 1;
      wait_drain(40);
      chk("wrap_count", word_count, sent % 256);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
